chacha_stream_ctrl: RTL

//  Sequencer for the fixed-latency, non-stallable ChaCha20 block core. Builds the 512-bit

---
 rtl/chacha_stream_ctrl.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/chacha_stream_ctrl.sv
// ChaCha20 block-core sequencer: builds core input states, tracks the fixed-latency core
// with a valid pipe, buffers results in a credit-bounded FIFO and streams keystream blocks.
module chacha_stream_ctrl #(
    parameter int CORE_LAT = 12,
    parameter int DEPTH    = 4,
    parameter int NB_W     = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic [255:0]    cfg_key,
    input  logic [95:0]     cfg_nonce,
    input  logic [31:0]     cfg_ctr0,
    input  logic [NB_W-1:0] num_blocks,
    output logic [511:0]    core_state,
    input  logic [511:0]    core_result,
    output logic [511:0]    ks_data,
    output logic            ks_valid,
    input  logic            ks_ready,
    output logic            busy,
    output logic            done,
    output logic            err_wrap
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int INF_W = $clog2(CORE_LAT + 1);
    localparam int SUM_W = ((CNT_W > INF_W) ? CNT_W : INF_W) + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [127:0]    SIGMA      = 128'h61707865_3320646e_79622d32_6b206574;
    localparam logic [NB_W-1:0] REM_ZERO   = {NB_W{1'b0}};
    localparam logic [NB_W-1:0] REM_ONE    = {{(NB_W-1){1'b0}}, 1'b1};
    localparam logic [SUM_W-1:0] CREDIT_MAX = SUM_W'(DEPTH);

    function automatic logic [511:0] build_state(input logic [255:0] key,
                                                 input logic [31:0]  ctr,
                                                 input logic [95:0]  nonce);
        return {SIGMA, key, ctr, nonce};
    endfunction

    logic [1:0]          state_r;
    logic [1:0]          state_nxt_s;
    logic [255:0]        key_r;
    logic [95:0]         nonce_r;
    logic [31:0]         ctr_r;
    logic [NB_W-1:0]     rem_r;
    logic [CORE_LAT-1:0] vpipe_r;
    logic [INF_W-1:0]    inflight_r;
    logic [511:0]        fifo_mem_r [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_r;
    logic [PTR_W-1:0]    rd_ptr_r;
    logic [PTR_W-1:0]    rd_ptr_nxt_s;
    logic [CNT_W-1:0]    fifo_cnt_r;
    logic [CNT_W-1:0]    cnt_after_pop_s;
    logic [CNT_W-1:0]    fifo_cnt_nxt_s;
    logic [SUM_W-1:0]    credit_sum_s;
    logic [511:0]        head_nxt_s;
    logic [511:0]        core_state_r;
    logic [511:0]        ks_data_r;
    logic                ks_valid_r;
    logic                busy_r;
    logic                done_r;
    logic                err_wrap_r;
    logic                pop_s;
    logic                push_s;
    logic                issue_s;
    logic                wrap_hit_s;
    logic                start_acc_s;
    logic                done_nxt_s;

    // Handshake, issue credit and FIFO next-state decode
    always_comb begin
        pop_s        = ks_valid_r & ks_ready;
        push_s       = vpipe_r[CORE_LAT-1];
        credit_sum_s = SUM_W'(inflight_r) + SUM_W'(fifo_cnt_r);
        // A pop this cycle does not free credit until the next one
        if ((state_r == ST_RUN) && !abort && (rem_r != REM_ZERO) && (credit_sum_s < CREDIT_MAX)) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
        wrap_hit_s      = issue_s && (ctr_r == 32'hFFFF_FFFF) && (rem_r != REM_ONE);
        cnt_after_pop_s = fifo_cnt_r - CNT_W'(pop_s);
        fifo_cnt_nxt_s  = cnt_after_pop_s + CNT_W'(push_s);
        rd_ptr_nxt_s    = rd_ptr_r + PTR_W'(pop_s);
        if (cnt_after_pop_s != {CNT_W{1'b0}}) begin
            head_nxt_s = fifo_mem_r[rd_ptr_nxt_s];
        end else if (push_s) begin
            head_nxt_s = core_result;
        end else begin
            head_nxt_s = {512{1'b0}};
        end
    end

    // Job sequencing: abort overrides everything, including a coincident start
    always_comb begin
        state_nxt_s = state_r;
        start_acc_s = 1'b0;
        done_nxt_s  = 1'b0;
        if (abort) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        start_acc_s = 1'b1;
                        if (num_blocks == REM_ZERO) begin
                            done_nxt_s = 1'b1;
                        end else begin
                            state_nxt_s = ST_RUN;
                        end
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (issue_s && (wrap_hit_s || (rem_r == REM_ONE))) begin
                        state_nxt_s = ST_DRAIN;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    // Empty pipe plus a FIFO emptied by this cycle's pop counts as finished
                    if ((inflight_r == {INF_W{1'b0}}) && (cnt_after_pop_s == {CNT_W{1'b0}})) begin
                        done_nxt_s  = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_DRAIN;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // FSM state, job configuration, block counters and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            err_wrap_r <= 1'b0;
            key_r      <= {256{1'b0}};
            nonce_r    <= {96{1'b0}};
            ctr_r      <= 32'd0;
            rem_r      <= REM_ZERO;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s != ST_IDLE);
            done_r  <= done_nxt_s;
            if (start_acc_s) begin
                key_r      <= cfg_key;
                nonce_r    <= cfg_nonce;
                ctr_r      <= cfg_ctr0;
                rem_r      <= num_blocks;
                err_wrap_r <= 1'b0;
            end else if (issue_s) begin
                ctr_r      <= ctr_r + 32'd1;
                rem_r      <= wrap_hit_s ? REM_ZERO : (rem_r - REM_ONE);
                err_wrap_r <= err_wrap_r | wrap_hit_s;
            end
        end
    end

    // Core input register, loaded once per issued block
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_state_r <= {512{1'b0}};
        end else if (issue_s) begin
            core_state_r <= build_state(key_r, ctr_r, nonce_r);
        end
    end

    // Valid pipe mirrors the core latency; its top bit marks a result to capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vpipe_r    <= {CORE_LAT{1'b0}};
            inflight_r <= {INF_W{1'b0}};
        end else if (abort) begin
            vpipe_r    <= {CORE_LAT{1'b0}};
            inflight_r <= {INF_W{1'b0}};
        end else begin
            vpipe_r    <= {vpipe_r[CORE_LAT-2:0], issue_s};
            inflight_r <= inflight_r + INF_W'(issue_s) - INF_W'(push_s);
        end
    end

    // Result storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_mem_r[i] <= {512{1'b0}};
            end
        end else if (push_s && !abort) begin
            fifo_mem_r[wr_ptr_r] <= core_result;
        end
    end

    // FIFO pointers and registered stream outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            fifo_cnt_r <= {CNT_W{1'b0}};
            ks_valid_r <= 1'b0;
            ks_data_r  <= {512{1'b0}};
        end else if (abort) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            fifo_cnt_r <= {CNT_W{1'b0}};
            ks_valid_r <= 1'b0;
            ks_data_r  <= {512{1'b0}};
        end else begin
            wr_ptr_r   <= wr_ptr_r + PTR_W'(push_s);
            rd_ptr_r   <= rd_ptr_nxt_s;
            fifo_cnt_r <= fifo_cnt_nxt_s;
            ks_valid_r <= (fifo_cnt_nxt_s != {CNT_W{1'b0}});
            ks_data_r  <= head_nxt_s;
        end
    end

    assign core_state = core_state_r;
    assign ks_data    = ks_data_r;
    assign ks_valid   = ks_valid_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign err_wrap   = err_wrap_r;

endmodule
